// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide each take N iterations plus one
// sign-fix cycle. HI/LO feed the writeback result mux and hold between ops.

module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         START,
   input  logic [1:0]   OP,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         BUSY,
   output logic         DONE,
   output logic         DIVZ,
   output logic [N-1:0] HI,
   output logic [N-1:0] LO
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            isDiv_q, isDiv_d;
   logic            negRes_q, negRes_d;
   logic            negRem_q, negRem_d;
   logic            divByZero_q, divByZero_d;
   logic [N-1:0]    rawA_q, rawA_d;
   logic [N-1:0]    mag_q, mag_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [N-1:0]    low_q, low_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            divz_q, divz_d;
   logic [N-1:0]    hi_q, hi_d;
   logic [N-1:0]    lo_q, lo_d;

   logic            opSigned;
   logic [N-1:0]    absA, absB;
   logic [N:0]      mulSum;
   logic [N:0]      remShift;
   logic [N-1:0]    remDiff;
   logic            remFits;
   logic [2*N-1:0]  product, prodFix;
   logic [N-1:0]    quotFix, remFix;

   // State register plus the datapath and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         isDiv_q     <= 1'b0;
         negRes_q    <= 1'b0;
         negRem_q    <= 1'b0;
         divByZero_q <= 1'b0;
         rawA_q      <= '0;
         mag_q       <= '0;
         acc_q       <= '0;
         low_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         divz_q      <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         isDiv_q     <= isDiv_d;
         negRes_q    <= negRes_d;
         negRem_q    <= negRem_d;
         divByZero_q <= divByZero_d;
         rawA_q      <= rawA_d;
         mag_q       <= mag_d;
         acc_q       <= acc_d;
         low_q       <= low_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         divz_q      <= divz_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

   // Operand magnitudes and per-iteration arithmetic; the N+1-bit sums keep
   // the carry/borrow so the most negative operand needs no special case.
   always_comb begin
      opSigned = OP[0];
      absA     = (opSigned && A[N-1]) ? (~A + 1'b1) : A;
      absB     = (opSigned && B[N-1]) ? (~B + 1'b1) : B;
      mulSum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, mag_q} : {(N+1){1'b0}});
      remShift = {acc_q, low_q[N-1]};
      remFits  = (remShift >= {1'b0, mag_q});
      remDiff  = remShift[N-1:0] - mag_q;
      product  = {acc_q, low_q};
      prodFix  = negRes_q ? (~product + 1'b1) : product;
      quotFix  = negRes_q ? (~low_q + 1'b1) : low_q;
      remFix   = negRem_q ? (~acc_q + 1'b1) : acc_q;
   end

   // Next-state logic: capture in IDLE, iterate in CALC, sign-fix and publish in FIX.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      isDiv_d     = isDiv_q;
      negRes_d    = negRes_q;
      negRem_d    = negRem_q;
      divByZero_d = divByZero_q;
      rawA_d      = rawA_q;
      mag_d       = mag_q;
      acc_d       = acc_q;
      low_d       = low_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      divz_d      = divz_q;
      hi_d        = hi_q;
      lo_d        = lo_q;

      unique case (state_q)
         IDLE: begin
            if (START) begin
               isDiv_d     = OP[1];
               negRes_d    = opSigned && (A[N-1] ^ B[N-1]);
               negRem_d    = opSigned && OP[1] && A[N-1];
               divByZero_d = OP[1] && (B == '0);
               rawA_d      = A;
               acc_d       = '0;
               if (OP[1]) begin
                  low_d = absA;
                  mag_d = absB;
               end else begin
                  low_d = absB;
                  mag_d = absA;
               end
               cnt_d   = CW'(N);
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end

         CALC: begin
            if (isDiv_q) begin
               acc_d = remFits ? remDiff : remShift[N-1:0];
               low_d = {low_q[N-2:0], remFits};
            end else begin
               acc_d = mulSum[N:1];
               low_d = {mulSum[0], low_q[N-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (isDiv_q) begin
               if (divByZero_q) begin
                  hi_d   = rawA_q;
                  lo_d   = '1;
                  divz_d = 1'b1;
               end else begin
                  hi_d   = remFix;
                  lo_d   = quotFix;
                  divz_d = 1'b0;
               end
            end else begin
               hi_d   = prodFix[2*N-1:N];
               lo_d   = prodFix[N-1:0];
               divz_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign DIVZ = divz_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
